// File: rtl/s_term_dsp_turnaround.sv
// ============================================================================
// s_term_dsp_turnaround
// ----------------------------------------------------------------------------
// Bottom-edge termination tile for the DSP column. Every south-bound wire
// group arriving from the tile above is turned around into the matching
// north-bound group with its wire index reversed (OUT[i] = IN[W-1-i]).
// Each group is either bypassed (combinational) or retimed through one
// register stage. A 5-bit serially loaded configuration chain selects the
// mode of each group.
//
// Optional feature macro: S_TERM_DSP_BIST_EN
//    When defined, a walking-one BIST sequencer is added. It overrides the
//    52 north outputs with a one-hot pattern for 52 cycles.
//
// Ports:
//    UserCLK         in   1   single clock
//    resetn          in   1   synchronous, active-low reset
//    S1END           in   4   single-hop south-bound ends
//    S2MID           in   8   double-hop midpoints
//    S2END           in   8   double-hop ends
//    S4END           in  16   quad-hop ends
//    SS4END          in  16   long quad-hop ends
//    N1BEG           out  4   turned-around S1END
//    N2BEG           out  8   turned-around S2MID
//    N2BEGb          out  8   turned-around S2END
//    N4BEG           out 16   turned-around S4END
//    NN4BEG          out 16   turned-around SS4END
//    ConfigShiftEn   in   1   shift the configuration chain this cycle
//    ConfigShiftIn   in   1   serial configuration data in
//    ConfigShiftOut  out  1   serial configuration data out (cfg[4])
//    BistStart       in   1   start a BIST sweep (S_TERM_DSP_BIST_EN only)
//    BistActive      out  1   high while the sweep runs (S_TERM_DSP_BIST_EN only)
// ============================================================================
module s_term_dsp_turnaround #(
   parameter int CFG_BITS = 5,
   parameter int BIST_LEN = 52
) (
   input  logic        UserCLK,
   input  logic        resetn,
   input  logic [3:0]  S1END,
   input  logic [7:0]  S2MID,
   input  logic [7:0]  S2END,
   input  logic [15:0] S4END,
   input  logic [15:0] SS4END,
   output logic [3:0]  N1BEG,
   output logic [7:0]  N2BEG,
   output logic [7:0]  N2BEGb,
   output logic [15:0] N4BEG,
   output logic [15:0] NN4BEG,
   input  logic        ConfigShiftEn,
   input  logic        ConfigShiftIn,
   output logic        ConfigShiftOut
`ifdef S_TERM_DSP_BIST_EN
   ,
   input  logic        BistStart,
   output logic        BistActive
`endif
);

   // Bit positions of each group inside the configuration chain.
   localparam int CFG_N1  = 0;
   localparam int CFG_N2  = 1;
   localparam int CFG_N2B = 2;
   localparam int CFG_N4  = 3;
   localparam int CFG_NN4 = 4;

   logic [CFG_BITS-1:0] r_cfg;

   logic [3:0]  w_mirN1;
   logic [7:0]  w_mirN2;
   logic [7:0]  w_mirN2b;
   logic [15:0] w_mirN4;
   logic [15:0] w_mirNN4;

   logic [3:0]  r_pipeN1;
   logic [7:0]  r_pipeN2;
   logic [7:0]  r_pipeN2b;
   logic [15:0] r_pipeN4;
   logic [15:0] r_pipeNN4;

   logic [3:0]  w_muxN1;
   logic [7:0]  w_muxN2;
   logic [7:0]  w_muxN2b;
   logic [15:0] w_muxN4;
   logic [15:0] w_muxNN4;

   logic [BIST_LEN-1:0] w_flat;
   logic [BIST_LEN-1:0] w_out;

   // Index reversal of every group: the wire that arrives at the highest
   // south-bound index leaves on the lowest north-bound index.
   always_comb begin
      w_mirN1  = '0;
      w_mirN2  = '0;
      w_mirN2b = '0;
      w_mirN4  = '0;
      w_mirNN4 = '0;
      for (int i = 0; i < 4; i++) begin
         w_mirN1[i] = S1END[3-i];
      end
      for (int i = 0; i < 8; i++) begin
         w_mirN2[i]  = S2MID[7-i];
         w_mirN2b[i] = S2END[7-i];
      end
      for (int i = 0; i < 16; i++) begin
         w_mirN4[i]  = S4END[15-i];
         w_mirNN4[i] = SS4END[15-i];
      end
   end

   // The pipeline registers capture the mirrored inputs every cycle no matter
   // how the groups are configured, so flipping a group from bypass to
   // registered immediately presents valid, one-cycle-old data.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_pipeN1  <= '0;
         r_pipeN2  <= '0;
         r_pipeN2b <= '0;
         r_pipeN4  <= '0;
         r_pipeNN4 <= '0;
      end else begin
         r_pipeN1  <= w_mirN1;
         r_pipeN2  <= w_mirN2;
         r_pipeN2b <= w_mirN2b;
         r_pipeN4  <= w_mirN4;
         r_pipeNN4 <= w_mirNN4;
      end
   end

   // Serial configuration chain. New bits enter at cfg[0] and leave from
   // cfg[4]; the chain may be shifted at any time, including during BIST.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_cfg <= '0;
      end else if (ConfigShiftEn) begin
         r_cfg <= {r_cfg[CFG_BITS-2:0], ConfigShiftIn};
      end
   end

   assign ConfigShiftOut = r_cfg[CFG_BITS-1];

   // Per-group bypass/registered selection: a 0 in the chain passes the
   // mirrored input straight through, a 1 selects the retimed copy.
   always_comb begin
      w_muxN1  = r_cfg[CFG_N1]  ? r_pipeN1  : w_mirN1;
      w_muxN2  = r_cfg[CFG_N2]  ? r_pipeN2  : w_mirN2;
      w_muxN2b = r_cfg[CFG_N2B] ? r_pipeN2b : w_mirN2b;
      w_muxN4  = r_cfg[CFG_N4]  ? r_pipeN4  : w_mirN4;
      w_muxNN4 = r_cfg[CFG_NN4] ? r_pipeNN4 : w_mirNN4;
   end

   // Flattened view of all north outputs, N1 in the least significant bits
   // and NN4 in the most significant bits. The BIST walking one indexes
   // into this same ordering.
   assign w_flat = {w_muxNN4, w_muxN4, w_muxN2b, w_muxN2, w_muxN1};

`ifdef S_TERM_DSP_BIST_EN

   typedef enum logic {
      BIST_IDLE = 1'b0,
      BIST_RUN  = 1'b1
   } bist_state_t;

   localparam logic [5:0] BIST_LAST = 6'(BIST_LEN - 1);

   bist_state_t r_bistState;
   bist_state_t w_bistNext;
   logic [5:0]  r_bistIdx;
   logic [BIST_LEN-1:0] w_bistOneHot;

   // BIST state register; reset wins over a simultaneous start request.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_bistState <= BIST_IDLE;
      end else begin
         r_bistState <= w_bistNext;
      end
   end

   // Next-state logic: a start pulse is only honoured from IDLE, and the
   // sweep ends after the last wire index has been driven for one cycle.
   always_comb begin
      w_bistNext = r_bistState;
      case (r_bistState)
         BIST_IDLE: begin
            if (BistStart) begin
               w_bistNext = BIST_RUN;
            end
         end
         BIST_RUN: begin
            if (r_bistIdx == BIST_LAST) begin
               w_bistNext = BIST_IDLE;
            end
         end
         default: begin
            w_bistNext = BIST_IDLE;
         end
      endcase
   end

   // Wire index counter. It is parked at 0 while idle so that a new sweep
   // always begins on N1BEG[0].
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         r_bistIdx <= '0;
      end else if (r_bistState == BIST_RUN) begin
         if (r_bistIdx == BIST_LAST) begin
            r_bistIdx <= '0;
         end else begin
            r_bistIdx <= r_bistIdx + 6'd1;
         end
      end else begin
         r_bistIdx <= '0;
      end
   end

   // The one-hot is decoded purely from registered state, so the override
   // only changes right after a clock edge.
   always_comb begin
      w_bistOneHot = '0;
      w_bistOneHot[r_bistIdx] = 1'b1;
   end

   assign w_out      = (r_bistState == BIST_RUN) ? w_bistOneHot : w_flat;
   assign BistActive = (r_bistState == BIST_RUN);

`else

   assign w_out = w_flat;

`endif

   assign N1BEG  = w_out[3:0];
   assign N2BEG  = w_out[11:4];
   assign N2BEGb = w_out[19:12];
   assign N4BEG  = w_out[35:20];
   assign NN4BEG = w_out[51:36];

endmodule

// File: doc/s_term_dsp_turnaround.md
# s_term_dsp_turnaround

Bottom-edge termination tile for the DSP column. It turns every south-bound wire group arriving from the tile above into the matching north-bound group, with the wire index reversed. Each wire group can either pass straight through (bypass) or be retimed through one register stage. The bypass/register choice is set by a 5-bit serially loaded configuration chain.

## Interface
Parameters:
- `CFG_BITS`, 5: length of the configuration chain, one bit per wire group; fixed value.
- `BIST_LEN`, 52: total north-bound wires (4+8+8+16+16); fixed value.

Ports:
- `UserCLK`  in  1  single clock
- `resetn`  in  1  reset; synchronous and active-low
- `S1END`  in  4  single-hop south-bound ends
- `S2MID`  in  8  double-hop midpoints
- `S2END`  in  8  double-hop ends
- `S4END`  in  16  quad-hop ends
- `SS4END`  in  16  long quad-hop ends
- `N1BEG`  out  4  turned-around single-hop
- `N2BEG`  out  8  turned-around from S2MID
- `N2BEGb`  out  8  turned-around from S2END
- `N4BEG`  out  16  turned-around quad
- `NN4BEG`  out  16  turned-around long quad
- `ConfigShiftEn`  in  1  shift the configuration chain this cycle
- `ConfigShiftIn`  in  1  serial configuration data in
- `ConfigShiftOut`  out  1  serial out, equal to `cfg[4]`
- `BistStart`, `BistActive`  in/out  1 each  present only with `S_TERM_DSP_BIST_EN`

## Operation
- Mirror mapping, for each group of width W: `OUT[i] = IN[W-1-i]`.
  - `N1BEG` from `S1END`, `N2BEG` from `S2MID`, `N2BEGb` from `S2END`, `N4BEG` from `S4END`, `NN4BEG` from `SS4END`.
- Configuration bits:
  - `cfg[0]` selects N1, `cfg[1]` N2, `cfg[2]` N2b, `cfg[3]` N4, `cfg[4]` NN4.
  - Bit = 0: bypass; the group output is combinational from its input.
  - Bit = 1: registered; the group output comes from the pipeline register.
- Pipeline registers: all 52 capture the mirrored inputs every cycle, whatever the configuration. Switching a group from bypass to registered therefore needs no refill.
- Configuration shift: when `ConfigShiftEn`=1, `cfg <= {cfg[3:0], ConfigShiftIn}`. Otherwise `cfg` holds.
- After reset every group is in bypass.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - `cfg` and all pipeline registers go to 0; `ConfigShiftOut` = 0.
  - North outputs equal the mirrored inputs, because every group is in bypass.
  - `BistActive` = 0; the BIST counter goes to 0.
- Bypass latency is 0 cycles. Registered latency is 1 cycle.
- A new `cfg` value takes effect on the output mux in the cycle after the shift edge.
- Shifting is allowed at any time, including during BIST. Outputs glitch-switch at the clock edge only.
- `resetn` has priority over `ConfigShiftEn` and `BistStart` when they occur in the same cycle.

## Configuration
- Macro: `S_TERM_DSP_BIST_EN`.
- Defined: adds `BistStart` and `BistActive` and a 6-bit index counter (0..51). BIST is a state machine with two states:
  - IDLE → RUN on `BistStart`=1; the counter loads 0.
  - In RUN, the 52 north outputs (flattened in the order N1, N2, N2b, N4, NN4, LSB first) are overridden with a registered one-hot at the counter index. The index increments once per cycle.
  - After index 51, RUN → IDLE and the override is released on the next cycle.
  - `BistActive`=1 exactly while in RUN, which lasts 52 cycles.
  - `BistStart` during RUN is ignored.
  - Reset during RUN returns to IDLE immediately.
- Undefined: no BIST ports or logic; the outputs are always the mirror mapping.

## Test plan
- After reset, drive `S1END`=4'b0001 → `N1BEG`=4'b1000 in the same cycle; `ConfigShiftOut`=0.
- Shift in 1,0,0,0,0 over five cycles → `cfg`=5'b10000 (NN4 only registered).
  - `SS4END`=16'h0001 → `NN4BEG`=16'h8000 one cycle later.
  - `N4BEG` follows `S4END` immediately.
- With `cfg`=5'b11111, change all inputs at cycle t → every output updates at t+1 and not before. Shift one more bit → `ConfigShiftOut` shows the old `cfg[4]`.
- Assert `resetn`=0 for one cycle while `ConfigShiftEn`=1 with `cfg`=5'b11111 → `cfg`=0 and all groups are back in bypass the next cycle.
- BIST (macro on):
  - Pulse `BistStart` → `BistActive` is high for 52 cycles. `N1BEG[0]` is high in the first cycle and `NN4BEG[15]` in the last.
  - A second `BistStart` at cycle 10 has no effect.
- BIST (macro on), reset at cycle 20 → `BistActive`=0 and the mirror mapping is restored on the next cycle.
